// File: rtl/textmap_arbiter.sv
// Single-port text-map RAM owner: arbitrates CPU accesses against the built-in
// clear / scroll-up engine, alternating grants when both want the port.
module textmap_arbiter #(
    parameter int TEXT_COLS = 84,
    parameter int TEXT_ROWS = 24,
    parameter int ADDRW     = 11,
    parameter int WORD      = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [WORD-1:0]  cpu_wdata,
    output logic             cpu_ack,
    output logic             cpu_rvalid,
    output logic [WORD-1:0]  cpu_rdata,
    input  logic             cmd_valid,
    input  logic             cmd_op,
    input  logic [WORD-1:0]  cmd_fill,
    output logic             cmd_ready,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [WORD-1:0]  mem_wdata,
    input  logic [WORD-1:0]  mem_rdata
);

    localparam int N_CELLS = TEXT_COLS * TEXT_ROWS;
    localparam logic [ADDRW-1:0] LAST_CELL = ADDRW'(N_CELLS - 1);
    localparam logic [ADDRW-1:0] SCR_END   = ADDRW'((TEXT_ROWS - 1) * TEXT_COLS);
    localparam logic [ADDRW-1:0] COLS_A    = ADDRW'(TEXT_COLS);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SCR_RD, S_SCR_WR, S_FILL, S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [ADDRW-1:0] cnt, cnt_nx, cnt_inc;
    logic [WORD-1:0]  fill_q;
    logic [WORD-1:0]  scroll_q;
    logic             last_eng;

    logic             mem_en_q, mem_we_q, wsel_q, cpu_ack_q;
    logic [ADDRW-1:0] addr_q;
    logic [WORD-1:0]  wdata_q;
    logic [WORD-1:0]  cpu_rdata_q;

    // Read-owner tag pipeline: _p0 = read on the port now, _p1 = its data on mem_rdata now
    logic             rd_cpu_p0, rd_eng_p0;
    logic             rd_cpu_p1, rd_eng_p1;

    logic             accept, eng_req, cpu_rq, gnt_cpu, gnt_eng;
    logic             eng_we, eng_wsel;
    logic [ADDRW-1:0] eng_addr;
    logic [WORD-1:0]  eng_wdata, scroll_data;

    assign cmd_ready = (state == S_IDLE) || (state == S_DONE);
    assign busy      = !cmd_ready;
    assign done      = (state == S_DONE);
    assign accept    = cmd_valid && cmd_ready;

    assign eng_req = (state == S_CLR) || (state == S_SCR_RD) ||
                     (state == S_SCR_WR) || (state == S_FILL);
    assign cpu_rq  = cpu_req && !cpu_ack_q;
    assign gnt_cpu = cpu_rq && (!eng_req || last_eng);
    assign gnt_eng = eng_req && !gnt_cpu;

    assign cnt_inc     = cnt + ADDRW'(1);
    assign scroll_data = rd_eng_p1 ? mem_rdata : scroll_q;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        eng_we    = 1'b1;
        eng_wsel  = 1'b0;
        eng_addr  = cnt;
        eng_wdata = fill_q;
        case (state)
            S_CLR, S_FILL: begin
                if (gnt_eng) begin
                    cnt_nx = cnt_inc;
                    if (cnt == LAST_CELL) state_nx = S_DONE;
                end
            end
            S_SCR_RD: begin
                eng_we   = 1'b0;
                eng_addr = cnt + COLS_A;
                if (gnt_eng) state_nx = S_SCR_WR;
            end
            S_SCR_WR: begin
                // A write issued right behind its read takes the data straight off mem_rdata
                eng_wdata = scroll_data;
                eng_wsel  = rd_eng_p0;
                if (gnt_eng) begin
                    cnt_nx   = cnt_inc;
                    state_nx = (cnt_inc == SCR_END) ? S_FILL : S_SCR_RD;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (accept) begin
            cnt_nx = '0;
            if (!cmd_op)             state_nx = S_CLR;
            else if (TEXT_ROWS == 1) state_nx = S_FILL;
            else                     state_nx = S_SCR_RD;
        end
    end

    // Grant stage: register the winner onto the RAM port
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last_eng    <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wsel_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            rd_cpu_p0   <= 1'b0;
            rd_eng_p0   <= 1'b0;
            rd_cpu_p1   <= 1'b0;
            rd_eng_p1   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mem_en_q  <= gnt_cpu || gnt_eng;
            cpu_ack_q <= gnt_cpu;
            rd_cpu_p0 <= gnt_cpu && !cpu_we;
            rd_eng_p0 <= gnt_eng && !eng_we;
            rd_cpu_p1 <= rd_cpu_p0;
            rd_eng_p1 <= rd_eng_p0;
            if (gnt_cpu) begin
                mem_we_q <= cpu_we;
                addr_q   <= cpu_addr;
                wdata_q  <= cpu_wdata;
                wsel_q   <= 1'b0;
                last_eng <= 1'b0;
            end else if (gnt_eng) begin
                mem_we_q <= eng_we;
                addr_q   <= eng_addr;
                wdata_q  <= eng_wdata;
                wsel_q   <= eng_wsel;
                last_eng <= 1'b1;
            end else begin
                mem_we_q <= 1'b0;
                if (wsel_q) begin
                    wdata_q <= mem_rdata;
                    wsel_q  <= 1'b0;
                end
            end
            if (rd_cpu_p1) cpu_rdata_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (accept)    fill_q   <= cmd_fill;
        if (rd_eng_p1) scroll_q <= mem_rdata;
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wsel_q ? mem_rdata : wdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rvalid = rd_cpu_p1;
    assign cpu_rdata  = rd_cpu_p1 ? mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_textmap_arbiter.sv
// Directed bench for textmap_arbiter on a 4x3 text map with a 1-cycle RAM model.
module tb_textmap_arbiter;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int AW   = 11;
    localparam int W    = 16;
    localparam int N    = COLS * ROWS;

    logic          clk_sys = 1'b0;
    logic          rst_sys = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [W-1:0]  cpu_wdata = '0;
    logic          cpu_ack, cpu_rvalid;
    logic [W-1:0]  cpu_rdata;
    logic          cmd_valid = 1'b0, cmd_op = 1'b0;
    logic [W-1:0]  cmd_fill = '0;
    logic          cmd_ready, busy, done;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata, mem_rdata;

    logic [W-1:0]  ram [0:(1<<AW)-1];
    logic [AW-1:0] wlog_a [0:255];
    logic [W-1:0]  wlog_d [0:255];
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, eng_cnt = 0, done_cnt = 0;
    int n_chk = 0, n_fail = 0;

    textmap_arbiter #(.TEXT_COLS(COLS), .TEXT_ROWS(ROWS), .ADDRW(AW), .WORD(W)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
        .cmd_ready(cmd_ready), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    always @(negedge clk_sys) begin
        if (mem_en && mem_we) begin
            wlog_a[wr_cnt[7:0]] = mem_addr;
            wlog_d[wr_cnt[7:0]] = mem_wdata;
            wr_cnt++;
        end
        if (mem_en && !mem_we) rd_cnt++;
        if (mem_en && !cpu_ack) eng_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                              output int lat, output logic [1:0] en_we,
                              output logic [AW-1:0] ack_addr, output logic [W-1:0] rd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = 0; en_we = '0; ack_addr = '0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            lat++;
            if (cpu_ack) break;
        end
        if (!cpu_ack) chk("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
        en_we = {mem_en, mem_we};
        ack_addr = mem_addr;
        cpu_req = 1'b0; cpu_we = 1'b0;
        if (!we) begin
            @(negedge clk_sys);
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
            rd = cpu_rdata;
        end
    endtask

    task automatic start_cmd(input logic op, input logic [W-1:0] fill, output int k);
        cmd_valid = 1'b1; cmd_op = op; cmd_fill = fill;
        k = cyc;
        @(negedge clk_sys);
        cmd_valid = 1'b0; cmd_op = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                lat = cyc - k;
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_ready", 32'(cmd_ready), 32'd1);
                break;
            end
            @(negedge clk_sys);
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k, lat, s, r0, d0, e0, ja, nrd;
        logic [1:0] ew;
        logic [AW-1:0] aa;
        logic [W-1:0] rd, pend;
        bit first, stop;

        // Reset
        #2 rst_sys = 1'b1;
        #1;
        chk("rst_ctl", 32'({cmd_ready, busy, done, mem_en, mem_we, cpu_ack, cpu_rvalid}), 32'b1000000);
        chk("rst_data", 32'({mem_addr, mem_wdata}), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        @(negedge clk_sys); @(negedge clk_sys);
        rst_sys = 1'b0;
        @(negedge clk_sys);

        // Clear
        s = wr_cnt;
        start_cmd(1'b0, 16'h0020, k);
        wait_done(k, 40, lat);
        chk("clr_latency", 32'(lat), 32'd13);
        @(negedge clk_sys);
        chk("clr_wr_count", 32'(wr_cnt - s), 32'd12);
        for (int i = 0; i < N; i++)
            chk("clr_wr", {5'd0, wlog_a[8'(s + i)], wlog_d[8'(s + i)]}, {5'd0, AW'(i), 16'h0020});

        // CPU write then read while idle
        @(negedge clk_sys);
        cpu_access(1'b1, 11'd5, 16'hBEEF, lat, ew, aa, rd);
        chk("cpu_wr_lat", 32'(lat), 32'd1);
        chk("cpu_wr_port", {19'd0, ew, aa}, {19'd0, 2'b11, 11'd5});
        @(negedge clk_sys);
        cpu_access(1'b0, 11'd5, 16'h0000, lat, ew, aa, rd);
        chk("cpu_rd_lat", 32'(lat), 32'd1);
        chk("cpu_rd_port", {19'd0, ew, aa}, {19'd0, 2'b10, 11'd5});
        chk("cpu_rd_data", 32'(rd), 32'hBEEF);

        // Preload through the CPU port
        for (int i = 0; i < N; i++) cpu_access(1'b1, AW'(i), 16'(16'h0100 + i), lat, ew, aa, rd);
        for (int j = 0; j < 4; j++) cpu_access(1'b1, AW'(100 + j), 16'(16'h0500 + j), lat, ew, aa, rd);
        @(negedge clk_sys);

        // Scroll up
        r0 = rd_cnt;
        start_cmd(1'b1, 16'h0000, k);
        wait_done(k, 60, lat);
        chk("scr_latency", 32'(lat), 32'd21);
        @(negedge clk_sys);
        chk("scr_reads", 32'(rd_cnt - r0), 32'd8);
        for (int i = 0; i < N; i++)
            chk("scr_cell", {AW'(i), ram[AW'(i)]}, {AW'(i), (i < 8) ? 16'(16'h0104 + i) : 16'h0000});

        // Clear under continuous CPU reads
        s = wr_cnt;
        start_cmd(1'b0, 16'h0041, k);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd100;
        first = 1'b1; stop = 1'b0; lat = -1; nrd = 0; pend = '0;
        for (int it = 0; it < 80; it++) begin
            @(negedge clk_sys);
            if (first) begin
                chk("ctn_first_cpu", 32'({cpu_ack, mem_en, mem_we}), 32'b110);
                first = 1'b0;
            end
            if (cpu_rvalid) begin
                chk("ctn_rdata", 32'(cpu_rdata), 32'(pend));
                nrd++;
                if (!cpu_req) break;
            end
            if (done && lat < 0) begin
                lat = cyc - k;
                stop = 1'b1;
            end
            if (cpu_ack) begin
                ja = int'(cpu_addr) - 100;
                pend = 16'(16'h0500 + ja);
                if (stop) cpu_req = 1'b0;
                else      cpu_addr = AW'(100 + (ja + 1) % 4);
            end
        end
        cpu_req = 1'b0;
        chk("ctn_latency", 32'(lat), 32'd25);
        chk("ctn_cpu_reads", 32'(nrd), 32'd13);
        chk("ctn_wr_count", 32'(wr_cnt - s), 32'd12);
        for (int i = 0; i < N; i++)
            chk("ctn_wr", {5'd0, wlog_a[8'(s + i)], wlog_d[8'(s + i)]}, {5'd0, AW'(i), 16'h0041});

        // Reset in the middle of a scroll
        @(negedge clk_sys);
        d0 = done_cnt; e0 = eng_cnt;
        start_cmd(1'b1, 16'h7777, k);
        for (int i = 0; i < 30; i++) begin
            if (eng_cnt - e0 >= 5) break;
            @(negedge clk_sys);
        end
        chk("mid_busy", 32'(busy), 32'd1);
        rst_sys = 1'b1;
        #1;
        chk("mid_rst_ctl", 32'({cmd_ready, busy, done, mem_en, mem_we, cpu_ack, cpu_rvalid}), 32'b1000000);
        chk("mid_rst_data", 32'({mem_addr, mem_wdata}), 32'd0);
        @(negedge clk_sys);
        rst_sys = 1'b0;
        repeat (30) @(negedge clk_sys);
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        start_cmd(1'b0, 16'h0055, k);
        wait_done(k, 40, lat);
        chk("post_rst_latency", 32'(lat), 32'd13);
        @(negedge clk_sys);
        for (int i = 0; i < N; i++)
            chk("post_rst_cell", {AW'(i), ram[AW'(i)]}, {AW'(i), 16'h0055});

        // Command while busy is dropped
        @(negedge clk_sys);
        r0 = rd_cnt; d0 = done_cnt;
        start_cmd(1'b0, 16'h0066, k);
        @(negedge clk_sys);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_fill = 16'h9999;
        @(negedge clk_sys);
        cmd_valid = 1'b0; cmd_op = 1'b0;
        wait_done(k, 40, lat);
        chk("busy_latency", 32'(lat), 32'd13);
        repeat (30) @(negedge clk_sys);
        chk("busy_done_count", 32'(done_cnt - d0), 32'd1);
        chk("busy_no_reads", 32'(rd_cnt - r0), 32'd0);
        chk("busy_cell0", 32'(ram[0]), 32'h0066);
        chk("busy_idle_ready", 32'({cmd_ready, busy}), 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
